// File: rtl/pow2_clk_mon_pkg.sv
// Shared state type and sizing helpers for the power-of-two divided-clock monitor.
package pow2_clk_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_CHECK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_ERROR   = 3'd4
  } mon_state_t;

  // Period counter must hold 2^MAX_LOG2 plus headroom to see an overrun.
  function automatic int cnt_width(input int max_log2);
    return max_log2 + 2;
  endfunction

  // Exponents past the 32-bit range collapse to 0; callers reject them separately.
  function automatic int unsigned pow2_ratio(input int unsigned n);
    return (n < 32) ? (32'd1 << n) : 32'd0;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain that brings an asynchronous level into the local clock domain.
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pow2_div_clock_monitor.sv
// Samples a divided clock as data, emits edge strobes, measures its period and
// tracks lock/error against the programmed 2^N ratio.
module pow2_div_clock_monitor
  import pow2_clk_mon_pkg::*;
#(
  parameter int  MAX_LOG2     = 8,
  parameter int  SYNC_STAGES  = 2,
  parameter int  LOCK_PERIODS = 4,
  localparam int CNT_W        = cnt_width(MAX_LOG2),
  localparam int LOG_W        = $clog2(MAX_LOG2 + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_div_clk,
  input  logic             io_enable,
  input  logic             io_clear,
  input  logic [LOG_W-1:0] io_expected_log2,
  output logic             io_rise_pulse,
  output logic             io_fall_pulse,
  output logic             io_locked,
  output logic             io_error,
  output logic [CNT_W-1:0] io_last_period
);

  localparam int                 MATCH_W    = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [LOG_W-1:0]   LOG2_MAX   = LOG_W'(MAX_LOG2);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_PERIODS - 1);

  mon_state_t         state_reg, state_next;
  logic [MATCH_W-1:0] match_reg, match_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   exp_period;
  logic               div_sync;
  logic               div_dly_reg;
  logic               rise;
  logic               fall;
  logic               log2_legal;
  logic               period_ok;

  sync_ff_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_div_clk),
    .q     (div_sync)
  );

  assign rise       = div_sync & ~div_dly_reg;
  assign fall       = ~div_sync & div_dly_reg;
  assign log2_legal = (io_expected_log2 != '0) && (io_expected_log2 <= LOG2_MAX);
  assign exp_period = CNT_W'(pow2_ratio(32'(io_expected_log2)));
  // cnt_reg equals the full rise-to-rise distance on the cycle the next rise is seen.
  assign period_ok  = (cnt_reg == exp_period);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_dly_reg   <= 1'b0;
      io_rise_pulse <= 1'b0;
      io_fall_pulse <= 1'b0;
    end else begin
      div_dly_reg   <= div_sync;
      io_rise_pulse <= rise & io_enable;
      io_fall_pulse <= fall & io_enable;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg        <= '0;
      io_last_period <= '0;
    end else begin
      if (!io_enable) begin
        cnt_reg <= '0;
      end else if (rise) begin
        cnt_reg <= CNT_W'(1);
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // The ACQUIRE-phase rise closes a partial period, so it is never published.
      if (io_enable && rise && (state_reg == ST_CHECK || state_reg == ST_LOCKED)) begin
        io_last_period <= cnt_reg;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      match_reg <= '0;
    end else begin
      state_reg <= state_next;
      match_reg <= match_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    match_next = match_reg;
    if (!io_enable) begin
      state_next = ST_IDLE;
      match_next = '0;
    end else if (!log2_legal) begin
      state_next = ST_ERROR;
      match_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (rise) begin
            state_next = ST_CHECK;
            match_next = '0;
          end
        end
        ST_CHECK: begin
          if (rise) begin
            if (!period_ok) begin
              match_next = '0;
            end else if (match_reg == MATCH_LAST) begin
              state_next = ST_LOCKED;
              match_next = '0;
            end else begin
              match_next = match_reg + MATCH_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          // A wrong period or an overdue rise both mean the divider slipped.
          if ((rise && !period_ok) || (!rise && cnt_reg > exp_period)) begin
            state_next = ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (io_clear) begin
            state_next = ST_ACQUIRE;
            match_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign io_locked = (state_reg == ST_LOCKED);
  assign io_error  = (state_reg == ST_ERROR);

endmodule
